pb_debouncer_multi: RTL and testbench

Parametrised multi-channel push-button debouncer with press, release and long-press event outputs. Each channel synchronises one raw button input to `clk`, debounces it with its own stability counter, and reports a clean pressed level plus single-cycle event pulses. It sits between the board button pins and any control logic (menu FSMs, counters, mode selectors) that consumes button events. Compared with the single-input debouncer, it adds asynchronous reset, configurable polarity and thresholds, and long-press detection.

---
 rtl/pb_debouncer_multi.sv | 101 ++++++++++
 tb/tb_pb_debouncer_multi.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/pb_debouncer_multi.sv
// Multi-channel push-button debouncer: 2-flop sync, stability counter,
// press/release/long-press single-cycle event pulses per channel.

module pb_debounce_lane #(
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic pb,
    output logic pressed,
    output logic press_pulse,
    output logic release_pulse,
    output logic long_pulse
);
    localparam int unsigned DW = $clog2(DEBOUNCE_CYCLES);
    localparam int unsigned HW = $clog2(HOLD_CYCLES + 1);
    localparam logic [DW-1:0] DLAST = DW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HMAX  = HW'(HOLD_CYCLES);
    localparam logic [HW-1:0] HLAST = HW'(HOLD_CYCLES - 1);
    localparam logic          POL   = (ACTIVE_LOW != 0);

    logic          sync0, sync1;
    logic [DW-1:0] dcnt;
    logic [HW-1:0] hcnt;
    logic          mismatch, flip, fall;

    assign mismatch = (sync1 != pressed);
    assign flip     = mismatch && (dcnt == DLAST);
    assign fall     = flip && pressed;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= pb ^ POL;
            sync1 <= sync0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dcnt          <= '0;
            pressed       <= 1'b0;
            press_pulse   <= 1'b0;
            release_pulse <= 1'b0;
        end else begin
            dcnt          <= (!mismatch || flip) ? '0 : dcnt + DW'(1);
            pressed       <= pressed ^ flip;
            press_pulse   <= flip && !pressed;
            release_pulse <= fall;
        end
    end

    // A release landing on the threshold edge wins, so long never pairs with release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hcnt       <= '0;
            long_pulse <= 1'b0;
        end else begin
            if (!pressed || fall)
                hcnt <= '0;
            else if (hcnt != HMAX)
                hcnt <= hcnt + HW'(1);
            long_pulse <= pressed && !fall && (hcnt == HLAST);
        end
    end
endmodule

module pb_debouncer_multi #(
    parameter int unsigned CHANNELS        = 4,
    parameter int unsigned DEBOUNCE_CYCLES = 65536,
    parameter int unsigned HOLD_CYCLES     = 25000000,
    parameter int unsigned ACTIVE_LOW      = 1
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [CHANNELS-1:0] pb,
    output logic [CHANNELS-1:0] pressed,
    output logic [CHANNELS-1:0] press_pulse,
    output logic [CHANNELS-1:0] release_pulse,
    output logic [CHANNELS-1:0] long_pulse
);
    for (genvar g = 0; g < CHANNELS; g++) begin : g_lane
        pb_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .HOLD_CYCLES    (HOLD_CYCLES),
            .ACTIVE_LOW     (ACTIVE_LOW)
        ) u_lane (
            .clk          (clk),
            .rst_n        (rst_n),
            .pb           (pb[g]),
            .pressed      (pressed[g]),
            .press_pulse  (press_pulse[g]),
            .release_pulse(release_pulse[g]),
            .long_pulse   (long_pulse[g])
        );
    end
endmodule

// File: tb/tb_pb_debouncer_multi.sv
// Directed + random bench for pb_debouncer_multi against a timestamp-based
// reference model of the debounce/hold rules.

module tb_pb_debouncer_multi;
    localparam int CH   = 4;
    localparam int DB   = 8;
    localparam int HOLD = 32;
    localparam int AL   = 1;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [CH-1:0] pb = '0;
    logic [CH-1:0] pressed, press_pulse, release_pulse, long_pulse;

    always #5 clk = ~clk;

    pb_debouncer_multi #(
        .CHANNELS(CH), .DEBOUNCE_CYCLES(DB), .HOLD_CYCLES(HOLD), .ACTIVE_LOW(AL)
    ) dut (
        .clk(clk), .rst_n(rst_n), .pb(pb), .pressed(pressed),
        .press_pulse(press_pulse), .release_pulse(release_pulse), .long_pulse(long_pulse)
    );

    int checks = 0;
    int failures = 0;
    longint cyc = 0;

    // reference model: logical samples from previous edges, mismatch run length,
    // debounced level, and the edge index of the last press
    bit     lv_d1[CH], lv_d2[CH];
    int     run_len[CH];
    bit     m_pr[CH], m_pp[CH], m_rp[CH], m_lp[CH];
    longint press_t[CH];
    int     n_pp[CH], n_rp[CH], n_lp[CH];

    function automatic void model_reset();
        for (int c = 0; c < CH; c++) begin
            lv_d1[c] = 0; lv_d2[c] = 0; run_len[c] = 0;
            m_pr[c] = 0; m_pp[c] = 0; m_rp[c] = 0; m_lp[c] = 0;
            press_t[c] = -1000;
        end
    endfunction

    function automatic void model_edge(logic [CH-1:0] pins, longint now);
        for (int c = 0; c < CH; c++) begin
            bit seen;
            seen = lv_d2[c];
            lv_d2[c] = lv_d1[c];
            lv_d1[c] = pins[c] ^ AL[0];
            m_pp[c] = 0; m_rp[c] = 0; m_lp[c] = 0;
            if (seen != m_pr[c]) begin
                run_len[c]++;
                if (run_len[c] == DB) begin
                    run_len[c] = 0;
                    m_pr[c] = !m_pr[c];
                    if (m_pr[c]) begin m_pp[c] = 1; press_t[c] = now; end
                    else m_rp[c] = 1;
                end
            end else run_len[c] = 0;
            if (m_pr[c] && !m_pp[c] && now == press_t[c] + HOLD) m_lp[c] = 1;
        end
    endfunction

    task automatic chk(input string tag, input logic [CH-1:0] obs, input logic [CH-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [CH-1:0] e_pr, e_pp, e_rp, e_lp;
        @(posedge clk);
        if (rst_n) model_edge(pb, cyc);
        else model_reset();
        cyc++;
        @(negedge clk);
        for (int c = 0; c < CH; c++) begin
            e_pr[c] = m_pr[c]; e_pp[c] = m_pp[c]; e_rp[c] = m_rp[c]; e_lp[c] = m_lp[c];
        end
        chk("pressed", pressed, e_pr);
        chk("press_pulse", press_pulse, e_pp);
        chk("release_pulse", release_pulse, e_rp);
        chk("long_pulse", long_pulse, e_lp);
        for (int c = 0; c < CH; c++) begin
            n_pp[c] += int'(press_pulse[c]);
            n_rp[c] += int'(release_pulse[c]);
            n_lp[c] += int'(long_pulse[c]);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    int base_pp, base_rp, base_lp;

    initial begin
        model_reset();
        for (int c = 0; c < CH; c++) begin n_pp[c] = 0; n_rp[c] = 0; n_lp[c] = 0; end

        // reset with every pin pressed
        pb = 4'b0000;
        run(4);
        chk("reset_pressed", pressed, 4'b0000);
        rst_n = 1'b1;
        run(9);
        chk("post_reset_not_yet", pressed, 4'b0000);
        run(1);
        chk("post_reset_pressed", pressed, 4'b1111);
        chk("post_reset_pp", press_pulse, 4'b1111);
        run(1);
        chk("post_reset_pp_clear", press_pulse, 4'b0000);
        pb = 4'b1111;
        run(12);
        chk("all_released", pressed, 4'b0000);

        // clean press on channel 0
        base_pp = n_pp[0];
        pb[0] = 1'b0;
        run(9);
        chk("clean_early", pressed, 4'b0000);
        run(1);
        chk("clean_pressed", pressed, 4'b0001);
        chk("clean_pp", press_pulse, 4'b0001);
        run(1);
        chk("clean_pp_once", press_pulse, 4'b0000);
        pb[0] = 1'b1;
        run(12);

        // bounce on channel 1, then settle pressed
        base_pp = n_pp[1];
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pb[1] = ~pb[1];
            step();
        end
        chk_int("bounce_no_press", n_pp[1], base_pp);
        pb[1] = 1'b0;
        run(12);
        chk_int("bounce_one_press", n_pp[1], base_pp + 1);
        pb[1] = 1'b1;
        run(12);

        // long press on channel 2
        base_pp = n_pp[2]; base_rp = n_rp[2]; base_lp = n_lp[2];
        pb[2] = 1'b0;
        run(60);
        chk_int("long_count", n_lp[2], base_lp + 1);
        pb[2] = 1'b1;
        run(12);
        chk_int("long_release", n_rp[2], base_rp + 1);

        // short press on channel 2
        base_pp = n_pp[2]; base_rp = n_rp[2]; base_lp = n_lp[2];
        pb[2] = 1'b0;
        run(20);
        pb[2] = 1'b1;
        run(12);
        chk_int("short_press", n_pp[2], base_pp + 1);
        chk_int("short_release", n_rp[2], base_rp + 1);
        chk_int("short_no_long", n_lp[2], base_lp);

        // reset while channel 3 is pressed
        pb = 4'b0111;
        run(12);
        chk("pre_reset_pressed", pressed, 4'b1000);
        base_pp = n_pp[3]; base_rp = n_rp[3];
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("reset_immediate", pressed, 4'b0000);
        run(3);
        rst_n = 1'b1;
        run(9);
        chk("repress_early", pressed, 4'b0000);
        run(1);
        chk("repress_pp", press_pulse, 4'b1000);
        chk_int("reset_no_release", n_rp[3], base_rp);
        pb = 4'b1111;
        run(12);

        // random traffic: independent flips with varied run lengths
        for (int i = 0; i < 3000; i++) begin
            for (int c = 0; c < CH; c++)
                if ($urandom_range(0, 13) == 0) pb[c] = ~pb[c];
            step();
        end
        pb = 4'b1111;
        run(12);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
